// File: rtl/fetch_unit_if.sv
// Fetch unit signal bundle: redirect input, instruction-memory bus and the
// decode-side instruction handshake. The master modport is the fetch unit.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_Redirect;
  logic [ADDR_WIDTH-1:0] i_RedirectAddress;
  logic                  o_MemReq;
  logic [ADDR_WIDTH-1:0] o_MemAddr;
  logic                  i_MemGrant;
  logic                  i_MemRespValid;
  logic [ADDR_WIDTH-1:0] i_MemRespData;
  logic                  i_MemRespError;
  logic                  o_InstrValid;
  logic [ADDR_WIDTH-1:0] o_InstrWord;
  logic [ADDR_WIDTH-1:0] o_InstrAddress;
  logic [1:0]            o_InstrFault;
  logic                  i_InstrReady;
  logic                  o_Halted;

  modport master (
    input  i_Redirect, i_RedirectAddress, i_MemGrant, i_MemRespValid,
           i_MemRespData, i_MemRespError, i_InstrReady,
    output o_MemReq, o_MemAddr, o_InstrValid, o_InstrWord, o_InstrAddress,
           o_InstrFault, o_Halted
  );

  modport slave (
    output i_Redirect, i_RedirectAddress, i_MemGrant, i_MemRespValid,
           i_MemRespData, i_MemRespError, i_InstrReady,
    input  o_MemReq, o_MemAddr, o_InstrValid, o_InstrWord, o_InstrAddress,
           o_InstrFault, o_Halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: pipelined word requests, in-order responses
// buffered in a prefetch FIFO, redirect flush with response discard, and
// misaligned / bus-error fault reporting.
//
// state | meaning
// FETCH | issuing requests while request credit is available
// HALT  | fetch stopped after a fault; FIFO drains; left only by redirect/reset
module fetch_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DEPTH        = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic          i_Clock,
  input logic          i_Reset,
  fetch_unit_if.master bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // Discards can pile up over back-to-back redirects, so give headroom.
  localparam int DISC_W = CNT_W + 4;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);
  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_BUS = 2'b10;

  typedef enum logic {FETCH, HALT} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      fifo_count, outstanding, out_after;
  logic [DISC_W-1:0]     discard;
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [ADDR_WIDTH-1:0] pc, resp_addr;
  logic [CNT_W:0]        in_flight;
  logic                  redirect, misaligned, credit_ok, grant;
  logic                  resp_drop, resp_take, bus_err, enq, deq, collapse, head_valid;

  logic [ADDR_WIDTH-1:0] word_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];
  logic [1:0]            fault_mem [DEPTH];

  assign redirect   = bus.i_Redirect;
  assign misaligned = redirect && (bus.i_RedirectAddress[1:0] != 2'b00);
  assign in_flight  = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok  = in_flight < (CNT_W+1)'(DEPTH);
  assign grant      = bus.o_MemReq && bus.i_MemGrant;
  assign resp_drop  = bus.i_MemRespValid && (discard != '0);
  assign resp_take  = bus.i_MemRespValid && (discard == '0);
  assign bus_err    = resp_take && bus.i_MemRespError && !redirect;
  assign enq        = resp_take && !redirect;
  assign head_valid = fifo_count != '0;
  assign deq        = head_valid && bus.i_InstrReady && !redirect;
  // Both a redirect and a bus error turn every still-outstanding request into a discard.
  assign collapse   = redirect || bus_err;
  assign out_after  = outstanding + CNT_W'(grant) - CNT_W'(resp_take);

  // Request gated by i_Reset so nothing is requested while reset is held.
  assign bus.o_MemReq       = i_Reset && (state == FETCH) && !redirect && credit_ok;
  assign bus.o_MemAddr      = pc;
  assign bus.o_Halted       = (state == HALT);
  assign bus.o_InstrValid   = head_valid;
  assign bus.o_InstrWord    = head_valid ? word_mem[rd_ptr]  : '0;
  assign bus.o_InstrAddress = head_valid ? addr_mem[rd_ptr]  : '0;
  assign bus.o_InstrFault   = head_valid ? fault_mem[rd_ptr] : FAULT_NONE;

  // State register.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) state <= FETCH;
    else          state <= state_next;
  end

  // Next state: redirect wins over a same-cycle bus error.
  always_comb begin
    state_next = state;
    if (redirect)     state_next = misaligned ? HALT : FETCH;
    else if (bus_err) state_next = HALT;
  end

  // Counters, fetch/response address and FIFO pointers.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      outstanding <= '0;
      discard     <= '0;
      pc          <= RESET_VECTOR;
      resp_addr   <= RESET_VECTOR;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      discard     <= discard - DISC_W'(resp_drop) + (collapse ? DISC_W'(out_after) : '0);
      outstanding <= collapse ? '0 : out_after;
      if (redirect) begin
        pc         <= bus.i_RedirectAddress;
        resp_addr  <= bus.i_RedirectAddress;
        rd_ptr     <= '0;
        wr_ptr     <= misaligned ? PTR_W'(1) : '0;
        fifo_count <= misaligned ? CNT_W'(1) : '0;
      end else begin
        if (grant)     pc        <= pc + STEP;
        if (resp_take) resp_addr <= resp_addr + STEP;
        if (enq)       wr_ptr    <= wr_ptr + PTR_W'(1);
        if (deq)       rd_ptr    <= rd_ptr + PTR_W'(1);
        fifo_count <= fifo_count + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  // FIFO storage; a misaligned redirect plants its fault entry in slot 0.
  always_ff @(posedge i_Clock) begin
    if (misaligned) begin
      word_mem[0]  <= '0;
      addr_mem[0]  <= bus.i_RedirectAddress;
      fault_mem[0] <= FAULT_MISALIGN;
    end else if (enq) begin
      word_mem[wr_ptr]  <= bus.i_MemRespError ? '0 : bus.i_MemRespData;
      addr_mem[wr_ptr]  <= resp_addr;
      fault_mem[wr_ptr] <= bus.i_MemRespError ? FAULT_BUS : FAULT_NONE;
    end
  end

endmodule
